dmem_port_arbiter: RTL and testbench
====================================

Name: dmem_port_arbiter

Overview:
- Shares the single byte-addressed data memory between two requesters: instruction fetch (I port, read-only, word) and load/store unit (D port, read/write, byte/half/word via F3).
- Sits between the pipeline front/back ends and the data memory.
- Drives the memory's mem_read/mem_write/F3/addr/data_in and captures its combinational read data.
- Provides per-port grant, registered response, and a stall output to the hazard unit.

Parameters:
- ADDR_W, 6, byte-address width of the memory.
- DATA_W, 32, data width; fixed at 32 and never overridden.
- STARVE_MAX, 3, consecutive denied I-port request cycles before the I port is forced to win.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request, held until granted.
- i_addr  in  ADDR_W  fetch byte address.
- i_gnt  out  1  fetch accepted this cycle (combinational).
- i_rvalid  out  1  fetch data valid (registered pulse).
- i_rdata  out  32  fetch data.
- d_req  in  1  load/store request, held until granted.
- d_we  in  1  1=store, 0=load.
- d_f3  in  3  funct3 (LB/LH/LW/LBU/LHU; stores use LB/LH/LW codes).
- d_addr  in  ADDR_W  byte address.
- d_wdata  in  32  store data.
- d_gnt  out  1  load/store accepted (combinational).
- d_rvalid  out  1  load data valid or store acknowledge (registered pulse).
- d_rdata  out  32  load data; 0 on store ack.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_f3  out  3  memory F3.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory combinational read data.
- stall  out  1  (i_req & ~i_gnt) | (d_req & ~d_gnt).

Behaviour:
- Three-stage pipeline: accept (cycle T) -> memory access (T+1) -> response (T+2). Throughput is one access per cycle.
- Accept stage:
  - At most one gnt per cycle.
  - Default priority: D over I.
  - When starve_cnt == STARVE_MAX and i_req=1, I wins and d_gnt=0.
  - Granted request (port id, we, f3, addr, wdata) is latched into the access register with acc_valid=1.
  - With no grant, acc_valid=0.
- Access stage:
  - When acc_valid, drive mem_* from the access register.
  - Fetch: mem_f3 = LW, mem_read=1, mem_write=0.
  - Load: mem_read=1, mem_write=0.
  - Store: mem_write=1, mem_read=0; the memory writes on the clk edge ending T+1.
  - When acc_valid=0, mem_read=mem_write=0 and mem_addr/mem_wdata/mem_f3 hold their previous values.
- Response stage:
  - On the edge ending T+1, mem_rdata (or 0 for a store) is registered to the owning port's rdata.
  - That port's rvalid is high for exactly cycle T+2; the other port's rvalid is 0.
  - rdata holds its value until the next response for the same port.
- Ordering: a load accepted at T+1 after a store accepted at T sees the stored data, because the write commits before the load's access cycle.
- starve_cnt:
  - Increments when i_req & ~i_gnt, saturating at STARVE_MAX.
  - Clears to 0 on i_gnt or when i_req=0.
- Simultaneous requests: exactly one is granted. The loser stays stalled and must hold its request stable.
- Unsupported store F3 (not LB/LH/LW): forwarded unchanged. The memory performs no write; the ack is still issued.
- Address: passed unmodified. Overflow of addr+1..+3 inside the memory is not the arbiter's concern.
- Reset (any time, including mid-access):
  - Clears acc_valid, starve_cnt, and all rvalid, gnt-related state, mem_read and mem_write.
  - Clears i_rdata, d_rdata, mem_addr, mem_f3 and mem_wdata to 0.
  - An in-flight access produces no response.

Optional Feature:
- DMEM_ARB_PERF_EN.
- Defined: adds output conflict_cnt[31:0], incremented every cycle with i_req & d_req. It wraps at 2^32, resets to 0, and is readable as a status value.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package/defines:
  - F3 codes (LB, LH, LW, LBU, LHU), reused from the existing defines.
  - Requester id constants PORT_I=0, PORT_D=1.
  - Response-routing encoding.
- One natural sub-module: arb_priority_sel. It is combinational priority plus the starvation counter, producing i_gnt/d_gnt and starve_cnt.
- The pipeline registers stay in the top module.

Test Plan:
- Reset with i_req=d_req=1 asserted -> no gnt until rst deasserts; all outputs 0 during reset.
- Lone fetch: i_addr=8 with mem word 0xDEADBEEF at 8..11 -> i_gnt at T, mem_read=1 with addr 8 at T+1, i_rvalid=1 with i_rdata=0xDEADBEEF at T+2.
- Store then load back-to-back: SW 0x12345678 @4, then LB @7 -> d_rvalid at T+2 with d_rdata=0, then at T+3 with d_rdata=0x00000012.
- Sign extension: LH @4 after storing 0x0000F00D -> d_rdata=0xFFFFF00D; LHU -> 0x0000F00D.
- Contention with STARVE_MAX=3: both requests held continuously -> d_gnt for 3 cycles, i_gnt on cycle 4, D resumes on cycle 5; stall=1 every cycle.
- Reset asserted during a load's access cycle -> no d_rvalid; after release, a fresh request completes with 2-cycle latency.

Source files
------------

// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for dmem_port_arbiter: F3 access codes, requester ids and response routing.
package dmem_port_arbiter_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        ROUTE_NONE = 2'd0,
        ROUTE_I    = 2'd1,
        ROUTE_D    = 2'd2
    } resp_route_e;

    function automatic resp_route_e route_of(input logic valid, input logic port);
        if (!valid)
            return ROUTE_NONE;
        return (port == PORT_D) ? ROUTE_D : ROUTE_I;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_arb_priority_sel.sv
// Accept-stage arbitration: D beats I unless I has been denied STARVE_MAX cycles in a row.
module arb_priority_sel
    import dmem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 3,
    parameter int CNT_W      = $clog2(STARVE_MAX + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_req,
    input  logic             d_req,
    output logic             i_gnt,
    output logic             d_gnt,
    output logic [CNT_W-1:0] starve_cnt
);

    logic force_i;

    // No grant is ever issued while reset is held.
    always_comb begin
        force_i = i_req && (starve_cnt == CNT_W'(STARVE_MAX));
        d_gnt   = ~rst & d_req & ~force_i;
        i_gnt   = ~rst & i_req & ~(d_req & ~force_i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (i_req && !i_gnt) begin
            if (starve_cnt != CNT_W'(STARVE_MAX))
                starve_cnt <= starve_cnt + CNT_W'(1);
        end else begin
            starve_cnt <= '0;
        end
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Two-port (fetch / load-store) arbiter in front of the data memory: accept -> access -> response.
// Optional macro DMEM_ARB_PERF_EN adds the conflict_cnt status counter.
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 6,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [2:0]        d_f3,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [2:0]        mem_f3,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              stall
`ifdef DMEM_ARB_PERF_EN
    ,
    output logic [31:0]       conflict_cnt
`endif
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0]  starve_cnt;
    logic              acc_valid;
    logic              acc_port;
    logic              acc_we;
    logic [2:0]        acc_f3;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_wdata;
    resp_route_e       route;

    arb_priority_sel #(
        .STARVE_MAX (STARVE_MAX),
        .CNT_W      (CNT_W)
    ) u_sel (
        .clk        (clk),
        .rst        (rst),
        .i_req      (i_req),
        .d_req      (d_req),
        .i_gnt      (i_gnt),
        .d_gnt      (d_gnt),
        .starve_cnt (starve_cnt)
    );

    always_comb assert (starve_cnt <= CNT_W'(STARVE_MAX));

    assign stall = ~rst & ((i_req & ~i_gnt) | (d_req & ~d_gnt));

    // Access fields only load on a grant, so mem_addr/f3/wdata hold across idle cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_valid <= 1'b0;
            acc_port  <= PORT_I;
            acc_we    <= 1'b0;
            acc_f3    <= '0;
            acc_addr  <= '0;
            acc_wdata <= '0;
        end else begin
            acc_valid <= i_gnt | d_gnt;
            if (d_gnt) begin
                acc_port  <= PORT_D;
                acc_we    <= d_we;
                acc_f3    <= d_f3;
                acc_addr  <= d_addr;
                acc_wdata <= d_wdata;
            end else if (i_gnt) begin
                acc_port  <= PORT_I;
                acc_we    <= 1'b0;
                acc_f3    <= F3_LW;
                acc_addr  <= i_addr;
            end
        end
    end

    assign mem_read  = acc_valid & ~acc_we;
    assign mem_write = acc_valid & acc_we;
    assign mem_f3    = acc_f3;
    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;
    assign route     = route_of(acc_valid, acc_port);

    // Stores are acknowledged with zero data; rdata holds until that port's next response.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            i_rdata  <= '0;
            d_rdata  <= '0;
        end else begin
            i_rvalid <= (route == ROUTE_I);
            d_rvalid <= (route == ROUTE_D);
            if (route == ROUTE_I)
                i_rdata <= mem_rdata;
            if (route == ROUTE_D)
                d_rdata <= acc_we ? '0 : mem_rdata;
        end
    end

`ifdef DMEM_ARB_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            conflict_cnt <= '0;
        else if (i_req && d_req)
            conflict_cnt <= conflict_cnt + 32'd1;
    end
`endif

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Self-checking bench for dmem_port_arbiter: directed scenarios plus randomized traffic
// against a transaction-level model with its own shadow memory.
module tb_dmem_port_arbiter;
    import dmem_port_arbiter_pkg::*;

    localparam int ADDR_W     = 6;
    localparam int STARVE_MAX = 3;
    localparam int MEM_BYTES  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_gnt;
    logic              i_rvalid;
    logic [31:0]       i_rdata;
    logic              d_req;
    logic              d_we;
    logic [2:0]        d_f3;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              mem_read;
    logic              mem_write;
    logic [2:0]        mem_f3;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              stall;
`ifdef DMEM_ARB_PERF_EN
    logic [31:0]       conflict_cnt;
`endif

    int checks   = 0;
    int failures = 0;

    dmem_port_arbiter #(
        .ADDR_W     (ADDR_W),
        .DATA_W     (32),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_f3      (d_f3),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_read  (mem_read),
        .mem_write (mem_write),
        .mem_f3    (mem_f3),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .stall     (stall)
`ifdef DMEM_ARB_PERF_EN
        ,
        .conflict_cnt (conflict_cnt)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] init_byte(input int k);
        case (k)
            8:       return 8'hEF;
            9:       return 8'hBE;
            10:      return 8'hAD;
            11:      return 8'hDE;
            default: return 8'(k * 29 + 7);
        endcase
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] f3, input logic [7:0] b0,
                                             input logic [7:0] b1, input logic [7:0] b2,
                                             input logic [7:0] b3);
        case (f3)
            F3_LB:   return {{24{b0[7]}}, b0};
            F3_LH:   return {{16{b1[7]}}, b1, b0};
            F3_LW:   return {b3, b2, b1, b0};
            F3_LBU:  return {24'h0, b0};
            F3_LHU:  return {16'h0, b1, b0};
            default: return 32'h0;
        endcase
    endfunction

    function automatic int store_len(input logic [2:0] f3);
        case (f3)
            F3_LB:   return 1;
            F3_LH:   return 2;
            F3_LW:   return 4;
            default: return 0;
        endcase
    endfunction

    // Little-endian byte memory on the DUT side: combinational read, write on the clock edge.
    logic [7:0] dev_mem [MEM_BYTES];

    always_comb
        mem_rdata = load_val(mem_f3, dev_mem[mem_addr], dev_mem[mem_addr + ADDR_W'(1)],
                             dev_mem[mem_addr + ADDR_W'(2)], dev_mem[mem_addr + ADDR_W'(3)]);

    initial begin
        for (int k = 0; k < MEM_BYTES; k++)
            dev_mem[k] = init_byte(k);
        forever begin
            @(posedge clk);
            if (mem_write)
                for (int k = 0; k < store_len(mem_f3); k++)
                    dev_mem[mem_addr + ADDR_W'(k)] = mem_wdata[8*k +: 8];
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        int                cyc;
        bit                is_d;
        bit                store;
        logic [2:0]        f3;
        logic [ADDR_W-1:0] addr;
        logic [31:0]       wdata;
        logic [31:0]       rdata;
    } txn_t;

    bit i_done = 1'b1;
    bit d_done = 1'b1;

    // Transaction model: accepted at cycle c, accessed at c+1, answered at c+2.
    initial begin
        logic [7:0]        shadow [MEM_BYTES];
        txn_t              pend [$];
        txn_t              t;
        int                cyc = 0;
        int                denied = 0;
        bit                eig, edg, exp_iv, exp_dv;
        logic [31:0]       exp_i_rdata = 0, exp_d_rdata = 0, last_wdata = 0;
        logic [ADDR_W-1:0] last_addr = 0;
        logic [2:0]        last_f3 = 0;
        logic [31:0]       exp_conf = 0;
        for (int k = 0; k < MEM_BYTES; k++)
            shadow[k] = init_byte(k);
        forever begin
            @(negedge clk);
            if (rst) begin
                checkOutput("rst_i_gnt", {31'b0, i_gnt}, 0);
                checkOutput("rst_d_gnt", {31'b0, d_gnt}, 0);
                checkOutput("rst_stall", {31'b0, stall}, 0);
                checkOutput("rst_mem_read", {31'b0, mem_read}, 0);
                checkOutput("rst_mem_write", {31'b0, mem_write}, 0);
                checkOutput("rst_mem_addr", {26'b0, mem_addr}, 0);
                checkOutput("rst_mem_f3", {29'b0, mem_f3}, 0);
                checkOutput("rst_mem_wdata", mem_wdata, 0);
                checkOutput("rst_i_rvalid", {31'b0, i_rvalid}, 0);
                checkOutput("rst_d_rvalid", {31'b0, d_rvalid}, 0);
                checkOutput("rst_i_rdata", i_rdata, 0);
                checkOutput("rst_d_rdata", d_rdata, 0);
                pend.delete();
                denied = 0;
                exp_i_rdata = 0;
                exp_d_rdata = 0;
                last_addr = 0;
                last_f3 = 0;
                last_wdata = 0;
                exp_conf = 0;
                i_done = 1'b1;
                d_done = 1'b1;
            end else begin
                eig = 1'b0;
                edg = 1'b0;
                if (i_req && denied >= STARVE_MAX) eig = 1'b1;
                else if (d_req)                    edg = 1'b1;
                else if (i_req)                    eig = 1'b1;
                checkOutput("i_gnt", {31'b0, i_gnt}, {31'b0, eig});
                checkOutput("d_gnt", {31'b0, d_gnt}, {31'b0, edg});
                checkOutput("stall", {31'b0, stall}, {31'b0, (i_req && !eig) || (d_req && !edg)});

                if (pend.size() > 0 && pend[pend.size()-1].cyc == cyc - 1) begin
                    t = pend[pend.size()-1];
                    last_addr = t.addr;
                    last_f3   = t.f3;
                    if (t.store) begin
                        last_wdata = t.wdata;
                        for (int k = 0; k < store_len(t.f3); k++)
                            shadow[t.addr + ADDR_W'(k)] = t.wdata[8*k +: 8];
                        t.rdata = 0;
                    end else begin
                        t.rdata = load_val(t.f3, shadow[t.addr], shadow[t.addr + ADDR_W'(1)],
                                           shadow[t.addr + ADDR_W'(2)], shadow[t.addr + ADDR_W'(3)]);
                    end
                    pend[pend.size()-1] = t;
                    checkOutput("mem_read", {31'b0, mem_read}, {31'b0, !t.store});
                    checkOutput("mem_write", {31'b0, mem_write}, {31'b0, t.store});
                    if (t.store)
                        checkOutput("mem_wdata", mem_wdata, last_wdata);
                end else begin
                    checkOutput("mem_read_idle", {31'b0, mem_read}, 0);
                    checkOutput("mem_write_idle", {31'b0, mem_write}, 0);
                end
                checkOutput("mem_addr", {26'b0, mem_addr}, {26'b0, last_addr});
                checkOutput("mem_f3", {29'b0, mem_f3}, {29'b0, last_f3});

                exp_iv = 1'b0;
                exp_dv = 1'b0;
                if (pend.size() > 0 && pend[0].cyc == cyc - 2) begin
                    t = pend.pop_front();
                    if (t.is_d) begin
                        exp_dv = 1'b1;
                        exp_d_rdata = t.rdata;
                    end else begin
                        exp_iv = 1'b1;
                        exp_i_rdata = t.rdata;
                    end
                end
                checkOutput("i_rvalid", {31'b0, i_rvalid}, {31'b0, exp_iv});
                checkOutput("d_rvalid", {31'b0, d_rvalid}, {31'b0, exp_dv});
                checkOutput("i_rdata", i_rdata, exp_i_rdata);
                checkOutput("d_rdata", d_rdata, exp_d_rdata);
`ifdef DMEM_ARB_PERF_EN
                checkOutput("conflict_cnt", conflict_cnt, exp_conf);
                if (i_req && d_req)
                    exp_conf = exp_conf + 1;
`endif

                if (i_req && !eig) denied = (denied < STARVE_MAX) ? denied + 1 : STARVE_MAX;
                else               denied = 0;
                if (edg) pend.push_back('{cyc, 1'b1, d_we, d_f3, d_addr, d_wdata, 32'h0});
                if (eig) pend.push_back('{cyc, 1'b0, 1'b0, F3_LW, i_addr, 32'h0, 32'h0});
                i_done = eig;
                d_done = edg;
            end
            cyc++;
        end
    end

    task automatic applyStimulus(input bit ir, input logic [ADDR_W-1:0] ia, input bit dr,
                                 input bit dwe, input logic [2:0] df3,
                                 input logic [ADDR_W-1:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        rst     = 1'b0;
        i_req   = ir;
        i_addr  = ia;
        d_req   = dr;
        d_we    = dwe;
        d_f3    = df3;
        d_addr  = da;
        d_wdata = dwd;
    endtask

    task automatic applyReset();
        @(posedge clk);
        #1;
        rst   = 1'b1;
        i_req = 1'b0;
        d_req = 1'b0;
    endtask

    task automatic idle();
        applyStimulus(0, 0, 0, 0, F3_LW, 0, 0);
    endtask

    initial begin
        logic [2:0] sf3;
        rst = 1'b1;
        i_req = 1'b1;
        d_req = 1'b1;
        i_addr = 0;
        d_we = 1'b0;
        d_f3 = F3_LW;
        d_addr = 0;
        d_wdata = 0;
        repeat (3) @(negedge clk);
        checkOutput("lit_reset_i_gnt", {31'b0, i_gnt}, 0);
        checkOutput("lit_reset_d_gnt", {31'b0, d_gnt}, 0);
        idle();
        idle();

        applyStimulus(1, 8, 0, 0, F3_LW, 0, 0);
        @(negedge clk);
        checkOutput("lit_fetch_gnt", {31'b0, i_gnt}, 1);
        idle();
        @(negedge clk);
        checkOutput("lit_fetch_mem_read", {31'b0, mem_read}, 1);
        checkOutput("lit_fetch_mem_addr", {26'b0, mem_addr}, 8);
        idle();
        @(negedge clk);
        checkOutput("lit_fetch_rvalid", {31'b0, i_rvalid}, 1);
        checkOutput("lit_fetch_rdata", i_rdata, 32'hDEADBEEF);

        applyStimulus(0, 0, 1, 1, F3_LW, 4, 32'h12345678);
        applyStimulus(0, 0, 1, 0, F3_LB, 7, 0);
        idle();
        @(negedge clk);
        checkOutput("lit_store_ack_valid", {31'b0, d_rvalid}, 1);
        checkOutput("lit_store_ack_data", d_rdata, 0);
        idle();
        @(negedge clk);
        checkOutput("lit_lb_valid", {31'b0, d_rvalid}, 1);
        checkOutput("lit_lb_data", d_rdata, 32'h00000012);

        applyStimulus(0, 0, 1, 1, F3_LW, 4, 32'h0000F00D);
        applyStimulus(0, 0, 1, 0, F3_LH, 4, 0);
        applyStimulus(0, 0, 1, 0, F3_LHU, 4, 0);
        idle();
        @(negedge clk);
        checkOutput("lit_lh_data", d_rdata, 32'hFFFFF00D);
        idle();
        @(negedge clk);
        checkOutput("lit_lhu_data", d_rdata, 32'h0000F00D);

        for (int k = 0; k < 5; k++) begin
            applyStimulus(1, 12, 1, 0, F3_LW, 16, 0);
            @(negedge clk);
            checkOutput("lit_contend_i_gnt", {31'b0, i_gnt}, (k == 3) ? 1 : 0);
            checkOutput("lit_contend_d_gnt", {31'b0, d_gnt}, (k == 3) ? 0 : 1);
            checkOutput("lit_contend_stall", {31'b0, stall}, 1);
        end
        repeat (3) idle();

        applyStimulus(0, 0, 1, 0, F3_LW, 20, 0);
        applyReset();
        idle();
        @(negedge clk);
        checkOutput("lit_rst_mid_no_rvalid", {31'b0, d_rvalid}, 0);
        applyStimulus(0, 0, 1, 0, F3_LW, 20, 0);
        idle();
        @(negedge clk);
        checkOutput("lit_after_rst_early", {31'b0, d_rvalid}, 0);
        idle();
        @(negedge clk);
        checkOutput("lit_after_rst_rvalid", {31'b0, d_rvalid}, 1);

        // Random traffic; an ungranted request is held stable until the model says it was taken.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                applyReset();
                continue;
            end
            if (i_req && !i_done)
                applyStimulus(i_req, i_addr, d_req, d_we, d_f3, d_addr, d_wdata);
            else
                applyStimulus($urandom_range(0, 99) < 55, ADDR_W'($urandom), d_req, d_we,
                              d_f3, d_addr, d_wdata);
            if (!(d_req && !d_done)) begin
                d_req   = $urandom_range(0, 99) < 60;
                d_we    = $urandom_range(0, 2) == 0;
                d_addr  = ADDR_W'($urandom);
                d_wdata = $urandom;
                case ($urandom_range(0, 4))
                    0:       sf3 = F3_LB;
                    1:       sf3 = F3_LH;
                    2:       sf3 = F3_LW;
                    3:       sf3 = F3_LBU;
                    default: sf3 = F3_LHU;
                endcase
                if (d_we)
                    sf3 = ($urandom_range(0, 9) == 0) ? 3'b011 : sf3[1:0] == 2'b11 ? F3_LW : {1'b0, sf3[1:0]};
                d_f3 = sf3;
            end
        end
        repeat (4) idle();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
